// File: rtl/jzjpcc_memory.sv
// jzjpcc RV32I memory stage: captures the execute request, runs one bus
// access at a time, formats load data and registers the writeback result.
// Params: DMEM_ADDR_MAX_B (highest driven bus address bit, default 31).
// Macro : JZJPCC_MEM_MISALIGN_TRAP_EN enables the misalignment check.
// Ports : clock/reset (async, active-high); *_execute request inputs;
//         bus* request/ready data bus; stall_memory upstream hold;
//         *_writeback result register; misaligned_memory sticky flag.
module jzjpcc_memory #(
  parameter int DMEM_ADDR_MAX_B = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [29:0] memAddress_execute,
  input  logic [1:0]  byteOffset_execute,
  input  logic [31:0] memDataToWrite_execute,
  input  logic [3:0]  memByteMask_execute,
  input  logic        memRead_execute,
  input  logic        memWrite_execute,
  input  logic [2:0]  loadFunct3_execute,
  input  logic [31:0] aluResult_execute,
  input  logic [4:0]  rdAddr_execute,
  input  logic        rdWriteEnable_execute,
  output logic        busRequest,
  output logic        busWrite,
  output logic [29:0] busAddress,
  output logic [31:0] busWriteData,
  output logic [3:0]  busByteEnable,
  input  logic        busReady,
  input  logic [31:0] busReadData,
  output logic        stall_memory,
  output logic [31:0] rdWriteData_writeback,
  output logic [4:0]  rdAddr_writeback,
  output logic        rdWriteEnable_writeback,
  output logic        misaligned_memory
);

  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        rd_en;
    logic        wr_en;
    logic [2:0]  funct3;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rd_we;
  } m_t;

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [31:0] FULL_MASK =
    (DMEM_ADDR_MAX_B >= 31) ? 32'hFFFF_FFFF :
    ((32'd1 << (DMEM_ADDR_MAX_B + 1)) - 32'd1);
  localparam logic [29:0] ADDR_MASK = FULL_MASK[31:2];

  m_t     m_q;
  m_t     m_d;
  state_t state;
  logic   mis;
  logic   [31:0] load_data;
  logic   [31:0] wb_data;
  logic   wb_we;
  logic   [7:0]  lane_b;
  logic   [15:0] lane_h;

  assign state = (m_q.valid && (m_q.rd_en || m_q.wr_en))
               ? ACCESS : IDLE;
  assign stall_memory = (state == ACCESS) && !busReady;

`ifdef JZJPCC_MEM_MISALIGN_TRAP_EN
  logic ld_half;
  logic ld_word;
  logic st_half;
  logic st_word;
  logic off_odd;
  logic off_nz;
  logic mis_q;

  always_comb begin
    ld_half = loadFunct3_execute[1:0] == 2'b01;
    ld_word = loadFunct3_execute[1:0] == 2'b10;
    st_half = $countones(memByteMask_execute) == 2;
    st_word = memByteMask_execute == 4'hF;
    off_odd = byteOffset_execute[0];
    off_nz  = byteOffset_execute != 2'b00;
    mis = 1'b0;
    if (memRead_execute)
      mis = (ld_half && off_odd) || (ld_word && off_nz);
    else if (memWrite_execute)
      mis = (st_half && off_odd) || (st_word && off_nz);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      mis_q <= 1'b0;
    else if (!stall_memory && mis)
      mis_q <= 1'b1;
  end

  assign misaligned_memory = mis_q;
`else
  assign mis = 1'b0;
  assign misaligned_memory = 1'b0;
`endif

  // A misaligned op enters M as a plain non-memory op with rd write
  // suppressed, so it never reaches ACCESS.
  always_comb begin
    m_d        = '0;
    m_d.valid  = 1'b1;
    m_d.addr   = memAddress_execute;
    m_d.off    = byteOffset_execute;
    m_d.wdata  = memDataToWrite_execute;
    m_d.mask   = memByteMask_execute;
    m_d.rd_en  = memRead_execute && !mis;
    m_d.wr_en  = memWrite_execute && !mis;
    m_d.funct3 = loadFunct3_execute;
    m_d.alu    = aluResult_execute;
    m_d.rd     = rdAddr_execute;
    m_d.rd_we  = rdWriteEnable_execute && !mis;
  end

  always_comb begin
    lane_b = 8'h00;
    unique case (m_q.off)
      2'd0: lane_b = busReadData[7:0];
      2'd1: lane_b = busReadData[15:8];
      2'd2: lane_b = busReadData[23:16];
      2'd3: lane_b = busReadData[31:24];
      default: lane_b = 8'h00;
    endcase
    lane_h = m_q.off[1] ? busReadData[31:16]
                        : busReadData[15:0];
    load_data = 32'h0;
    unique case (m_q.funct3)
      3'b000: load_data = {{24{lane_b[7]}}, lane_b};
      3'b001: load_data = {{16{lane_h[15]}}, lane_h};
      3'b010: load_data = busReadData;
      3'b100: load_data = {24'h0, lane_b};
      3'b101: load_data = {16'h0, lane_h};
      default: load_data = 32'h0;
    endcase
  end

  always_comb begin
    wb_data = m_q.rd_en ? load_data : m_q.alu;
    wb_we   = m_q.valid && m_q.rd_we && !m_q.wr_en;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q                     <= '0;
      rdWriteData_writeback   <= 32'h0;
      rdAddr_writeback        <= 5'h0;
      rdWriteEnable_writeback <= 1'b0;
    end else if (!stall_memory) begin
      m_q                     <= m_d;
      rdWriteData_writeback   <= wb_data;
      rdAddr_writeback        <= m_q.rd;
      rdWriteEnable_writeback <= wb_we;
    end
  end

  always_comb begin
    busRequest    = 1'b0;
    busWrite      = 1'b0;
    busAddress    = 30'h0;
    busWriteData  = 32'h0;
    busByteEnable = 4'h0;
    if (state == ACCESS) begin
      busRequest    = 1'b1;
      busWrite      = m_q.wr_en;
      busAddress    = m_q.addr & ADDR_MASK;
      busWriteData  = m_q.wr_en ? m_q.wdata : 32'h0;
      busByteEnable = m_q.wr_en ? m_q.mask : 4'h0;
    end
  end

endmodule

// File: tb/tb_jzjpcc_memory.sv
// Self-checking bench for jzjpcc_memory: table of single-cycle ops
// plus hand sequences for wait states, back-to-back, reset, misalign.
module tb_jzjpcc_memory;

  logic        clock = 1'b0;
  logic        reset;
  logic [29:0] memAddress_execute;
  logic [1:0]  byteOffset_execute;
  logic [31:0] memDataToWrite_execute;
  logic [3:0]  memByteMask_execute;
  logic        memRead_execute;
  logic        memWrite_execute;
  logic [2:0]  loadFunct3_execute;
  logic [31:0] aluResult_execute;
  logic [4:0]  rdAddr_execute;
  logic        rdWriteEnable_execute;
  logic        busRequest;
  logic        busWrite;
  logic [29:0] busAddress;
  logic [31:0] busWriteData;
  logic [3:0]  busByteEnable;
  logic        busReady;
  logic [31:0] busReadData;
  logic        stall_memory;
  logic [31:0] rdWriteData_writeback;
  logic [4:0]  rdAddr_writeback;
  logic        rdWriteEnable_writeback;
  logic        misaligned_memory;

  int n_chk = 0;
  int n_fail = 0;

  jzjpcc_memory dut (
    .clock(clock),
    .reset(reset),
    .memAddress_execute(memAddress_execute),
    .byteOffset_execute(byteOffset_execute),
    .memDataToWrite_execute(memDataToWrite_execute),
    .memByteMask_execute(memByteMask_execute),
    .memRead_execute(memRead_execute),
    .memWrite_execute(memWrite_execute),
    .loadFunct3_execute(loadFunct3_execute),
    .aluResult_execute(aluResult_execute),
    .rdAddr_execute(rdAddr_execute),
    .rdWriteEnable_execute(rdWriteEnable_execute),
    .busRequest(busRequest),
    .busWrite(busWrite),
    .busAddress(busAddress),
    .busWriteData(busWriteData),
    .busByteEnable(busByteEnable),
    .busReady(busReady),
    .busReadData(busReadData),
    .stall_memory(stall_memory),
    .rdWriteData_writeback(rdWriteData_writeback),
    .rdAddr_writeback(rdAddr_writeback),
    .rdWriteEnable_writeback(rdWriteEnable_writeback),
    .misaligned_memory(misaligned_memory)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rd_en;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [29:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu,
                       input logic [4:0] rd,
                       input logic we,
                       input logic rd_en,
                       input logic wr_en,
                       input logic [2:0] f3,
                       input logic [1:0] off,
                       input logic [29:0] addr,
                       input logic [31:0] wdata,
                       input logic [3:0] mask);
    aluResult_execute      = alu;
    rdAddr_execute         = rd;
    rdWriteEnable_execute  = we;
    memRead_execute        = rd_en;
    memWrite_execute       = wr_en;
    loadFunct3_execute     = f3;
    byteOffset_execute     = off;
    memAddress_execute     = addr;
    memDataToWrite_execute = wdata;
    memByteMask_execute    = mask;
  endtask

  task automatic nop();
    drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0,
          3'b0, 2'b0, 30'h0, 32'h0, 4'h0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [29:0] hold_addr;

  initial begin
    vecs[0]  = '{"alu", 32'h12345678, 5'd5, 1'b0, 3'b000,
                 2'd0, 30'h0, 32'h0, 32'h12345678};
    vecs[1]  = '{"lb2", 32'h0, 5'd6, 1'b1, 3'b000,
                 2'd2, 30'h10, 32'h0080FF00, 32'hFFFFFF80};
    vecs[2]  = '{"lbu2", 32'h0, 5'd7, 1'b1, 3'b100,
                 2'd2, 30'h11, 32'h0080FF00, 32'h00000080};
    vecs[3]  = '{"lh0", 32'h0, 5'd8, 1'b1, 3'b001,
                 2'd0, 30'h12, 32'h12348001, 32'hFFFF8001};
    vecs[4]  = '{"lhu2", 32'h0, 5'd9, 1'b1, 3'b101,
                 2'd2, 30'h13, 32'h8001ABCD, 32'h00008001};
    vecs[5]  = '{"lh2", 32'h0, 5'd10, 1'b1, 3'b001,
                 2'd2, 30'h14, 32'h8001ABCD, 32'hFFFF8001};
    vecs[6]  = '{"lw", 32'h0, 5'd11, 1'b1, 3'b010,
                 2'd0, 30'h15, 32'hCAFEBABE, 32'hCAFEBABE};
    vecs[7]  = '{"lb3", 32'h0, 5'd12, 1'b1, 3'b000,
                 2'd3, 30'h16, 32'h7F000000, 32'h0000007F};
    vecs[8]  = '{"f3bad", 32'h0, 5'd13, 1'b1, 3'b011,
                 2'd0, 30'h17, 32'hFFFFFFFF, 32'h00000000};
    vecs[9]  = '{"rd0", 32'h00000005, 5'd0, 1'b0, 3'b000,
                 2'd0, 30'h0, 32'h0, 32'h00000005};
    vecs[10] = '{"lb1", 32'h0, 5'd14, 1'b1, 3'b000,
                 2'd1, 30'h18, 32'h00008000, 32'hFFFFFF80};
    vecs[11] = '{"lbu0", 32'h0, 5'd15, 1'b1, 3'b100,
                 2'd0, 30'h19, 32'h000000FE, 32'h000000FE};

    reset = 1'b1;
    busReady = 1'b0;
    busReadData = 32'h0;
    nop();
    tick();
    chk("rst_req", {31'h0, busRequest}, 32'h0);
    chk("rst_stall", {31'h0, stall_memory}, 32'h0);
    chk("rst_we", {31'h0, rdWriteEnable_writeback}, 32'h0);
    chk("rst_data", rdWriteData_writeback, 32'h0);
    chk("rst_mis", {31'h0, misaligned_memory}, 32'h0);
    reset = 1'b0;
    tick();

    busReady = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].alu, vecs[i].rd, 1'b1, vecs[i].rd_en,
            1'b0, vecs[i].f3, vecs[i].off, vecs[i].addr,
            32'h0, 4'h0);
      busReadData = vecs[i].rdata;
      tick();
      nop();
      #1;
      chk({vecs[i].name, "_req"}, {31'h0, busRequest},
          {31'h0, vecs[i].rd_en});
      chk({vecs[i].name, "_stall"}, {31'h0, stall_memory}, 32'h0);
      if (vecs[i].rd_en) begin
        chk({vecs[i].name, "_addr"}, {2'b0, busAddress},
            {2'b0, vecs[i].addr});
        chk({vecs[i].name, "_be"}, {28'h0, busByteEnable}, 32'h0);
      end
      tick();
      chk({vecs[i].name, "_data"}, rdWriteData_writeback,
          vecs[i].exp);
      chk({vecs[i].name, "_rd"}, {27'h0, rdAddr_writeback},
          {27'h0, vecs[i].rd});
      chk({vecs[i].name, "_we"},
          {31'h0, rdWriteEnable_writeback}, 32'h1);
    end

    busReady = 1'b0;
    drive(32'h0, 5'd20, 1'b1, 1'b1, 1'b0, 3'b101,
          2'd2, 30'h2A, 32'h0, 4'h0);
    tick();
    hold_addr = busAddress;
    drive(32'h55, 5'd21, 1'b1, 1'b0, 1'b0, 3'b000,
          2'd0, 30'h3F, 32'h0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      chk("wait_stall", {31'h0, stall_memory}, 32'h1);
      chk("wait_req", {31'h0, busRequest}, 32'h1);
      chk("wait_addr", {2'b0, busAddress}, {2'b0, 30'h2A});
      chk("wait_stable", {2'b0, busAddress}, {2'b0, hold_addr});
      if (c < 2) tick();
    end
    busReady = 1'b1;
    busReadData = 32'h8001ABCD;
    #1;
    chk("wait_rel", {31'h0, stall_memory}, 32'h0);
    tick();
    chk("wait_data", rdWriteData_writeback, 32'h00008001);
    chk("wait_rd", {27'h0, rdAddr_writeback}, 32'd20);
    nop();
    tick();
    chk("wait_alu", rdWriteData_writeback, 32'h55);

    drive(32'h100, 5'd4, 1'b1, 1'b0, 1'b1, 3'b010,
          2'd0, 30'h40, 32'hDEADBEEF, 4'hF);
    tick();
    chk("sw_req", {31'h0, busRequest}, 32'h1);
    chk("sw_wr", {31'h0, busWrite}, 32'h1);
    chk("sw_addr", {2'b0, busAddress}, 32'h40);
    chk("sw_wd", busWriteData, 32'hDEADBEEF);
    chk("sw_be", {28'h0, busByteEnable}, 32'hF);
    drive(32'h104, 5'd7, 1'b1, 1'b1, 1'b0, 3'b010,
          2'd0, 30'h41, 32'h0, 4'h0);
    busReadData = 32'h11223344;
    tick();
    chk("lw_req", {31'h0, busRequest}, 32'h1);
    chk("lw_wr", {31'h0, busWrite}, 32'h0);
    chk("lw_addr", {2'b0, busAddress}, 32'h41);
    chk("lw_be", {28'h0, busByteEnable}, 32'h0);
    chk("sw_we", {31'h0, rdWriteEnable_writeback}, 32'h0);
    nop();
    tick();
    chk("lw_data", rdWriteData_writeback, 32'h11223344);
    chk("lw_we", {31'h0, rdWriteEnable_writeback}, 32'h1);
    chk("lw_idle", {31'h0, busRequest}, 32'h0);

    drive(32'hABCD, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000,
          2'd0, 30'h0, 32'h0, 4'h0);
    tick();
    busReady = 1'b0;
    drive(32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010,
          2'd0, 30'h77, 32'h0, 4'h0);
    tick();
    chk("pre_rst_stall", {31'h0, stall_memory}, 32'h1);
    chk("pre_rst_we", {31'h0, rdWriteEnable_writeback}, 32'h1);
    nop();
    reset = 1'b1;
    #1;
    chk("mid_rst_req", {31'h0, busRequest}, 32'h0);
    chk("mid_rst_stall", {31'h0, stall_memory}, 32'h0);
    chk("mid_rst_we", {31'h0, rdWriteEnable_writeback}, 32'h0);
    chk("mid_rst_data", rdWriteData_writeback, 32'h0);
    #2;
    reset = 1'b0;
    tick();
    chk("post_rst_req", {31'h0, busRequest}, 32'h0);
    chk("post_rst_stall", {31'h0, stall_memory}, 32'h0);

    busReady = 1'b1;
    busReadData = 32'h01020304;
    drive(32'h0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b010,
          2'd1, 30'h22, 32'h0, 4'h0);
    tick();
    nop();
`ifdef JZJPCC_MEM_MISALIGN_TRAP_EN
    chk("mis_req", {31'h0, busRequest}, 32'h0);
    chk("mis_flag", {31'h0, misaligned_memory}, 32'h1);
    tick();
    chk("mis_we", {31'h0, rdWriteEnable_writeback}, 32'h0);
    tick();
    chk("mis_sticky", {31'h0, misaligned_memory}, 32'h1);
`else
    chk("mis_req", {31'h0, busRequest}, 32'h1);
    chk("mis_addr", {2'b0, busAddress}, 32'h22);
    tick();
    chk("mis_data", rdWriteData_writeback, 32'h01020304);
    chk("mis_flag", {31'h0, misaligned_memory}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jzjpcc_memory.md
# jzjpcc_memory

Memory stage of the jzjpcc pipelined RV32I core. Captures the execute stage's combinational memory request (word address, write data, byte mask) and its ALU/rd control, then performs the load or store over a single-outstanding data bus with a request/ready handshake. Formats load data (lane select, sign/zero extension) and registers the writeback result. Stalls upstream stages while a bus access is outstanding.

## Interface
- DMEM_ADDR_MAX_B, default 31: highest driven bus address bit; bits above are ignored on the bus and driven 0.
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high
- memAddress_execute  input  30  word address [31:2] from execute ALU
- byteOffset_execute  input  2  ALU result [1:0]
- memDataToWrite_execute  input  32  lane-aligned store data
- memByteMask_execute  input  4  store byte enables
- memRead_execute / memWrite_execute  input  1 each  load / store request (never both)
- loadFunct3_execute  input  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- aluResult_execute  input  32  non-memory result
- rdAddr_execute  input  5;  rdWriteEnable_execute  input  1
- busRequest  output  1;  busWrite  output  1;  busAddress  output  30 [31:2];  busWriteData  output  32;  busByteEnable  output  4
- busReady  input  1  access completes at the edge where busRequest && busReady
- busReadData  input  32  valid when busReady
- stall_memory  output  1  hold execute and earlier stages
- rdWriteData_writeback  output  32;  rdAddr_writeback  output  5;  rdWriteEnable_writeback  output  1
- misaligned_memory  output  1  sticky misalignment flag (see Configuration)

## Operation
- Internal M register holds one instruction: address, offset, data, mask, read/write, funct3, aluResult, rd fields, valid.
- States: IDLE (M holds no memory op), ACCESS (M holds load/store). State is derived from M contents; no separate next-state path.
- stall_memory = ACCESS && !busReady (combinational).
- Every edge with stall_memory low: WB register <= result of M; M <= execute inputs. With stall high, M and WB hold.
- Bus outputs in ACCESS driven from M: busRequest 1, busWrite = M write, busAddress = M address, busWriteData/busByteEnable from M (byte enable 0000 on loads). In IDLE all bus outputs 0.
- Request stays asserted and all bus outputs stable until busReady seen; no back-to-back gap required (ACCESS to ACCESS when the next op is also memory).
- Load result: select lane by offset; LB/LBU byte [8*off+7:8*off], LH/LHU halfword off[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW whole word. Undefined funct3 yields 0.
- Non-memory op: WB data = aluResult. Store: rdWriteEnable_writeback forced 0.
- rdAddr 0 passes through; register file ignores it.

## Timing
- Non-memory op: one-cycle latency execute -> writeback.
- Load/store: completes at first edge with busReady high in ACCESS; minimum one cycle (busReady already high), plus one per waited cycle.
- Reset (any time, including mid-access): M invalid, WB outputs 0, rdWriteEnable_writeback 0, all bus outputs 0, stall_memory 0, misaligned_memory 0; in-flight access abandoned immediately.
- busReady while IDLE is ignored.

## Configuration
- JZJPCC_MEM_MISALIGN_TRAP_EN defined: LH/LHU/store-half at offset 3 or odd, LW/SW offset not 00 is misaligned; no bus request issued (state stays IDLE), rd write suppressed, misaligned_memory set and held until reset.
- Undefined: no check; address aligned down, misaligned_memory tied 0, lanes selected from offset as-is.

## Test plan
- ALU op aluResult 0x12345678, rd 5 -> next cycle rdWriteData_writeback 0x12345678, rdAddr 5, enable 1; busRequest never high.
- LB offset 2, busReadData 0x0080FF00, busReady held high -> one-cycle access, writeback 0xFFFFFF80; stall_memory never high.
- LHU offset 2, busReady low 3 cycles then high, busReadData 0x8001ABCD -> stall_memory high 3 cycles, bus outputs stable, writeback 0x00008001.
- SW addr 0x100, data 0xDEADBEEF, mask 1111 followed immediately by LW addr 0x104 -> busRequest continuous, second access address 0x41, store writes no rd.
- Reset asserted mid-ACCESS with busReady low -> busRequest, stall_memory, rdWriteEnable_writeback 0 same cycle; after release IDLE.
- With JZJPCC_MEM_MISALIGN_TRAP_EN, LW offset 01 -> no busRequest, misaligned_memory 1 sticky, rdWriteEnable_writeback 0.
